// File: rtl/uart_transmitter.sv
// uart_transmitter
// Serial transmit stage of the UART link. Accepts one byte per request and
// shifts it out LSB first as an asynchronous frame: one start bit, eight
// data bits, an optional even-parity bit, and one stop bit.
//
// Build option: define UART_PARITY_EN to add the even-parity bit (11-bit
// frame). Leave it undefined for the plain 10-bit frame. The setting has to
// match the receiver build, or the receiver will flag parity errors.
//
// Output timing: all three outputs are registered copies of the state held
// during the previous cycle. A request sampled at edge N therefore shows up
// on the line at edge N+1. The end-of-frame pulse appears one edge after the
// FSM has already returned to IDLE. This lets a request held high through
// the tx_done cycle be accepted on that same edge.
`timescale 1ns/1ps

module uart_transmitter #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transmit,
    input  logic [7:0] data_tx,
    output logic       serial_data_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    // Clock cycles per line bit, truncated toward zero.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

    // Baud counter spans 0 .. CLKS_PER_BIT-1. The guard keeps the width
    // legal long enough for the elaboration check below to report.
    localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Refuse to build a transmitter that cannot hold a bit for two cycles.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_transmitter: CLK_FREQ / BAUD_RATE must be at least 2");
        end
    endgenerate

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             frame_end;
    logic             frame_end_n;
    logic             bit_end;
    logic             line_n;
    logic             busy_n;
`ifdef UART_PARITY_EN
    logic             parity_bit;
    logic             parity_n;
`endif

    // The terminal count of the baud counter marks the last cycle of a bit.
    assign bit_end = (cnt == CNT_LAST);

    // FSM state, baud counter, bit index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_end <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            frame_end <= frame_end_n;
`ifdef UART_PARITY_EN
            parity_bit <= parity_n;
`endif
        end
    end

    // Next-state logic: walk START, DATA (8 bits), optional PARITY, and STOP.
    // Each state lasts one full baud period.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        frame_end_n = 1'b0;
`ifdef UART_PARITY_EN
        parity_n    = parity_bit;
`endif
        case (state)
            IDLE: begin
                // Capture the byte here. Later changes on data_tx cannot
                // reach the frame already in flight.
                if (transmit) begin
                    state_n   = START;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    shreg_n   = data_tx;
`ifdef UART_PARITY_EN
                    parity_n  = ^data_tx;
`endif
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
`ifdef UART_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    cnt_n       = '0;
                    state_n     = IDLE;
                    frame_end_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Line level and busy flag implied by the state held during this cycle.
    // These values are registered on the next edge.
    always_comb begin
        line_n = 1'b1;
        busy_n = (state != IDLE);
        case (state)
            START:   line_n = 1'b0;
            DATA:    line_n = shreg[0];
`ifdef UART_PARITY_EN
            PARITY:  line_n = parity_bit;
`endif
            default: line_n = 1'b1;
        endcase
    end

    // Registered outputs, so no input can reach the pins combinationally.
    // Reset forces the line high at once and abandons any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serial_data_tx <= 1'b1;
            tx_busy        <= 1'b0;
            tx_done        <= 1'b0;
        end else begin
            serial_data_tx <= line_n;
            tx_busy        <= busy_n;
            tx_done        <= frame_end;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
// Directed bench for uart_transmitter at 1 MHz / 100 kbaud (10 clocks per bit).
// A frame-level model predicts line, busy and done for every cycle from the
// accepted requests. Hand-written frame bit patterns and cycle spacings pin
// the model itself. Works with and without UART_PARITY_EN.
`timescale 1ns/1ps

module tb_uart_transmitter;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int C         = 10;

`ifdef UART_PARITY_EN
    localparam int  F            = 11;
    localparam bit  PAR          = 1'b1;
    localparam int  FRAME_CYCLES = 110;
    localparam int  PERIOD       = 111;
    // Line bits indexed by bit position (bit 0 = start); unused positions are 1.
    localparam logic [10:0] BITS_A5 = 11'b10101001010;
    localparam logic [10:0] BITS_07 = 11'b11000001110;
    localparam logic [10:0] BITS_00 = 11'b10000000000;
    localparam logic [10:0] BITS_FF = 11'b10111111110;
    localparam logic [10:0] BITS_55 = 11'b10010101010;
`else
    localparam int  F            = 10;
    localparam bit  PAR          = 1'b0;
    localparam int  FRAME_CYCLES = 100;
    localparam int  PERIOD       = 101;
    localparam logic [10:0] BITS_A5 = 11'b11101001010;
    localparam logic [10:0] BITS_07 = 11'b11000001110;
    localparam logic [10:0] BITS_00 = 11'b11000000000;
    localparam logic [10:0] BITS_FF = 11'b11111111110;
    localparam logic [10:0] BITS_55 = 11'b11010101010;
`endif
    localparam int FC = F * C;

    logic       clk = 1'b0;
    logic       reset;
    logic       transmit;
    logic [7:0] data_tx;
    logic       serial_data_tx;
    logic       tx_busy;
    logic       tx_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    int   starts[$];
    int   done_q[$];
    logic line_hist [0:16383];
    logic busy_q = 1'b0;

    uart_transmitter #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .transmit       (transmit),
        .data_tx        (data_tx),
        .serial_data_tx (serial_data_tx),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done)
    );

    // 100 MHz simulation clock; only the cycle count matters.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_value(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic record_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s at cycle %0d: expected event did not occur", name, cyc);
    endtask

    // Frame-level model. It remembers when the current frame was accepted and
    // derives each cycle's outputs from the frame layout.
    bit         m_active    = 1'b0;
    int         m_start     = 0;
    logic [7:0] m_byte      = 8'h00;
    int         m_prev_done = -1000;
    logic       exp_line    = 1'b1;
    logic       exp_busy    = 1'b0;
    logic       exp_done    = 1'b0;

    always @(posedge clk) begin : model_blk
        int d;
        int p;
        cyc++;
        if (reset) begin
            m_active    = 1'b0;
            m_prev_done = -1000;
        end else if (transmit && (!m_active || cyc >= m_start + FC + 1)) begin
            m_prev_done = m_active ? (m_start + FC + 1) : -1000;
            m_active    = 1'b1;
            m_start     = cyc;
            m_byte      = data_tx;
        end
        exp_line = 1'b1;
        exp_busy = 1'b0;
        exp_done = (cyc == m_prev_done);
        if (m_active && !reset) begin
            d = cyc - m_start;
            if (d >= 1 && d <= FC) begin
                exp_busy = 1'b1;
                p = (d - 1) / C;
                if (p == 0)
                    exp_line = 1'b0;
                else if (p <= 8)
                    exp_line = m_byte[p-1];
                else if (PAR && p == 9)
                    exp_line = ^m_byte;
                else
                    exp_line = 1'b1;
            end
            if (d == FC + 1)
                exp_done = 1'b1;
        end
    end

    // Compare every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        check_output("line", serial_data_tx, exp_line);
        check_output("busy", tx_busy, exp_busy);
        check_output("done", tx_done, exp_done);
    end

    // Log line history, busy rising edges and done pulses for frame checks.
    always @(posedge clk) begin
        #1;
        if (cyc < 16384)
            line_hist[cyc] = serial_data_tx;
        if (tx_busy && !busy_q)
            starts.push_back(cyc);
        if (tx_done)
            done_q.push_back(cyc);
        busy_q = tx_busy;
    end

    function automatic logic [10:0] decode_frame(input int s);
        logic [10:0] r;
        r = '1;
        for (int p = 0; p < F; p++) begin
            if (s + p * C + C / 2 < 16384)
                r[p] = line_hist[s + p * C + C / 2];
        end
        return r;
    endfunction

    task automatic clear_logs();
        starts.delete();
        done_q.delete();
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        @(negedge clk);
        transmit = 1'b1;
        data_tx  = b;
        @(negedge clk);
        transmit = 1'b0;
    endtask

    task automatic check_frame(input string name, input int idx, input logic [10:0] exp);
        if (starts.size() > idx)
            check_value(name, decode_frame(starts[idx]), exp);
        else
            record_fail(name);
    endtask

    task automatic wait_starts(input int n, input int limit);
        for (int i = 0; i < limit && starts.size() < n; i++)
            @(negedge clk);
        if (starts.size() < n)
            record_fail("start_timeout");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main_blk
        logic [7:0]  lb [3];
        logic [10:0] bits;
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h5A;

        reset    = 1'b1;
        transmit = 1'b0;
        data_tx  = 8'h00;

        // Reset values, then a quiet idle line.
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_line", serial_data_tx, 1'b1);
        check_output("reset_busy", tx_busy, 1'b0);
        check_output("reset_done", tx_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (50) @(negedge clk);
        check_value("idle_frames", starts.size(), 0);
        check_output("idle_line", serial_data_tx, 1'b1);

        // Single frame 0xA5.
        clear_logs();
        apply_stimulus(8'hA5);
        repeat (FC + 20) @(negedge clk);
        check_value("a5_frames", starts.size(), 1);
        check_value("a5_dones", done_q.size(), 1);
        check_frame("a5_bits", 0, BITS_A5);
        if (starts.size() > 0 && done_q.size() > 0)
            check_value("a5_busy_len", done_q[0] - starts[0], FRAME_CYCLES);
        else
            record_fail("a5_busy_len");

        // Single frame 0x07 (odd number of ones).
        clear_logs();
        apply_stimulus(8'h07);
        repeat (FC + 20) @(negedge clk);
        check_frame("x07_bits", 0, BITS_07);
        if (starts.size() > 0)
            check_output("x07_bit9", decode_frame(starts[0]) >> 9, 1'b1);

        // Request while busy is dropped.
        clear_logs();
        apply_stimulus(8'hA5);
        repeat (28) @(negedge clk);
        transmit = 1'b1;
        data_tx  = 8'h3C;
        @(negedge clk);
        transmit = 1'b0;
        repeat (FC + 30) @(negedge clk);
        check_value("busy_req_frames", starts.size(), 1);
        check_frame("busy_req_bits", 0, BITS_A5);

        // Back-to-back frames with transmit held high.
        clear_logs();
        @(negedge clk);
        transmit = 1'b1;
        data_tx  = 8'h00;
        wait_starts(1, 20);
        repeat (3) @(negedge clk);
        data_tx = 8'hFF;
        wait_starts(2, FC + 30);
        transmit = 1'b0;
        repeat (FC + 20) @(negedge clk);
        check_value("b2b_frames", starts.size(), 2);
        check_frame("b2b_bits0", 0, BITS_00);
        check_frame("b2b_bits1", 1, BITS_FF);
        if (starts.size() >= 2 && done_q.size() >= 1) begin
            check_value("b2b_period", starts[1] - starts[0], PERIOD);
            check_value("b2b_gap", starts[1] - done_q[0], 1);
        end else begin
            record_fail("b2b_period");
        end

        // Reset during data bit 3 aborts the frame with no done pulse.
        clear_logs();
        apply_stimulus(8'h00);
        repeat (4 * C + 3) @(negedge clk);
        check_output("bit3_low", serial_data_tx, 1'b0);
        reset = 1'b1;
        #1;
        check_output("abort_line", serial_data_tx, 1'b1);
        check_output("abort_busy", tx_busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (FC) @(negedge clk);
        check_value("abort_dones", done_q.size(), 0);
        clear_logs();
        apply_stimulus(8'h55);
        repeat (FC + 20) @(negedge clk);
        check_frame("after_abort_bits", 0, BITS_55);

        // Loopback: decode the line as a receiver would.
        for (int i = 0; i < 3; i++) begin
            clear_logs();
            apply_stimulus(lb[i]);
            repeat (FC + 20) @(negedge clk);
            if (starts.size() > 0) begin
                bits = decode_frame(starts[0]);
                check_value("loop_byte", bits[8:1], lb[i]);
                check_output("loop_stop", bits[F-1], 1'b1);
`ifdef UART_PARITY_EN
                check_output("loop_parity", bits[9], ^bits[8:1]);
`endif
            end else begin
                record_fail("loop_frame");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
